pw_stream_ctrl: RTL and testbench

Streaming sequencer for one fully-unrolled pointwise convolution layer in the synthetic MobileNet pipeline. It accepts input pixels (all input channels packed in one word) over a valid/ready handshake, issues them to the fixed-latency pointwise datapath, and captures the datapath results in an output FIFO. It presents the results downstream with valid/ready backpressure and marks frame boundaries. The datapath cannot stall, so issue is credit-gated against output FIFO space.

---
 rtl/pw_stream_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pw_stream_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_stream_ctrl.sv
// Pointwise-layer stream sequencer: credit-gated issue into a fixed-latency
// datapath, result capture in a small FIFO, and frame-boundary signalling.
module pw_stream_ctrl #(
    parameter int IN_W       = 64,
    parameter int OUT_W      = 128,
    parameter int DP_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int FMAP_W     = 16,
    parameter int FMAP_H     = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             s_valid,
    input  logic [IN_W-1:0]  s_data,
    output logic             s_ready,
    output logic             dp_valid,
    output logic [IN_W-1:0]  dp_act,
    input  logic             dp_ready,
    input  logic [OUT_W-1:0] dp_out,
    output logic             m_valid,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (FMAP_W > 1) ? $clog2(FMAP_W) : 1;
    localparam int RW = (FMAP_H > 1) ? $clog2(FMAP_H) : 1;
    localparam int SW = $clog2(FIFO_DEPTH + DP_LAT + 1) + 1;
    localparam logic [CW-1:0] COL_MAX = CW'(FMAP_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(FMAP_H - 1);
    localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q;
    logic [CW-1:0]           col_q;
    logic [RW-1:0]           row_q;
    logic [DP_LAT-1:0]       infl_q, infl_d;
    logic [DP_LAT-1:0]       tag_q, tag_d;
    logic                    busy_q, frame_done_q, err_q;

    logic [OUT_W-1:0]        mem_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]   mem_last_q;
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             count_q, count_d;

    logic [SW-1:0]           inflight;
    logic                    accept, is_last, empty, full, pop, push;
    logic                    dp_match, err_set, drain_done;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < DP_LAT; i++) begin
            inflight = inflight + SW'(infl_q[i]);
        end
    end

    // Credit counts only registered occupancy, so a same-cycle pop never
    // lets an extra pixel through.
    assign s_ready  = (state_q == RUN) && ((SW'(count_q) + inflight) < DEPTH_S);
    assign accept   = s_valid && s_ready;
    assign is_last  = (col_q == COL_MAX) && (row_q == ROW_MAX);
    assign dp_valid = accept;
    assign dp_act   = accept ? s_data : '0;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign m_valid  = !empty;
    assign m_data   = mem_data_q[rd_ptr_q];
    assign m_last   = !empty && mem_last_q[rd_ptr_q];
    assign pop      = m_valid && m_ready;

    // Results are matched to the tag leaving the end of the issue pipeline.
    assign dp_match = dp_ready && infl_q[DP_LAT-1];
    assign push     = dp_match && (!full || pop);
    assign err_set  = dp_ready && (!infl_q[DP_LAT-1] || (full && !pop));
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    assign infl_d     = (infl_q << 1) | DP_LAT'(accept);
    assign tag_d      = (tag_q << 1) | DP_LAT'(accept && is_last);
    assign drain_done = (count_d == '0) && (infl_d == '0);

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign err        = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            infl_q       <= '0;
            tag_q        <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            infl_q       <= infl_d;
            tag_q        <= tag_d;
            frame_done_q <= 1'b0;
            if (err_set) err_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        col_q   <= '0;
                        row_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (col_q == COL_MAX) begin
                            col_q <= '0;
                            row_q <= (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                        if (is_last) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Decided on next-state occupancy so the pulse lands
                    // the cycle right after the final pop.
                    if (drain_done) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            mem_last_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= dp_out;
                mem_last_q[wr_ptr_q] <= tag_q[DP_LAT-1];
                wr_ptr_q             <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_pw_stream_ctrl.sv
// Randomized bench for pw_stream_ctrl against a transaction-level model of the
// pixel stream, credit window, output latency and frame lifecycle.
module tb_pw_stream_ctrl;
  localparam int IN_W = 64;
  localparam int OUT_W = 128;
  localparam int DP_LAT = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int FMAP_W = 3;
  localparam int FMAP_H = 2;
  localparam int NPIX = FMAP_W * FMAP_H;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic s_valid = 1'b0;
  logic [IN_W-1:0] s_data = '0;
  logic s_ready;
  logic dp_valid;
  logic [IN_W-1:0] dp_act;
  logic dp_ready;
  logic [OUT_W-1:0] dp_out;
  logic m_valid;
  logic [OUT_W-1:0] m_data;
  logic m_last;
  logic m_ready = 1'b0;
  logic busy;
  logic frame_done;
  logic err;

  pw_stream_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DP_LAT(DP_LAT), .FIFO_DEPTH(FIFO_DEPTH),
    .FMAP_W(FMAP_W), .FMAP_H(FMAP_H)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .dp_valid(dp_valid), .dp_act(dp_act), .dp_ready(dp_ready), .dp_out(dp_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- datapath stand-in (one-cycle pipeline) ----------------
  function automatic logic [OUT_W-1:0] dp_fn(input logic [IN_W-1:0] a);
    return {a ^ 64'hA5A5_5A5A_0F0F_F0F0, a + 64'd3};
  endfunction

  logic dp_v_q = 1'b0;
  logic [OUT_W-1:0] dp_o_q = '0;
  logic spur = 1'b0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dp_v_q <= 1'b0;
      dp_o_q <= '0;
    end else begin
      dp_v_q <= dp_valid;
      dp_o_q <= dp_fn(dp_act);
    end
  end
  assign dp_ready = dp_v_q | spur;
  assign dp_out = dp_o_q;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus drivers ----------------
  // mode: 0 = low, 1 = high, 2 = random (mostly high), 3 = toggle
  int sv_mode = 0;
  int mr_mode = 0;
  always @(posedge clk) begin
    #1;
    s_data = {$urandom, $urandom};
    case (sv_mode)
      0: s_valid = 1'b0;
      1: s_valid = 1'b1;
      2: s_valid = ($urandom_range(0, 3) != 0);
      default: s_valid = ~s_valid;
    endcase
    case (mr_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      2: m_ready = ($urandom_range(0, 2) != 0);
      default: m_ready = ~m_ready;
    endcase
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk("frame_done_seen", 128'(seen), 128'(1'b1));
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [OUT_W:0] exp_q[$];
  int avail_q[$];
  int cyc = 0;
  bit m_busy = 0, m_run = 0, m_fd = 0, m_err = 0;
  int m_occ = 0;
  int m_acc = 0;

  always @(negedge clk) begin
    bit start_ok;
    logic [OUT_W:0] e;
    cyc++;
    if (!rstn) begin
      chk("rst_busy", 128'(busy), 128'(1'b0));
      chk("rst_s_ready", 128'(s_ready), 128'(1'b0));
      chk("rst_m_valid", 128'(m_valid), 128'(1'b0));
      chk("rst_err", 128'(err), 128'(1'b0));
      chk("rst_frame_done", 128'(frame_done), 128'(1'b0));
      exp_q.delete();
      avail_q.delete();
      m_busy = 0; m_run = 0; m_fd = 0; m_err = 0; m_occ = 0; m_acc = 0;
    end else begin
      start_ok = start && !m_busy;
      chk("busy", 128'(busy), 128'(m_busy));
      chk("s_ready", 128'(s_ready), 128'(m_run && (m_occ < FIFO_DEPTH)));
      chk("frame_done", 128'(frame_done), 128'(m_fd));
      chk("err", 128'(err), 128'(m_err));
      chk("m_valid", 128'(m_valid), 128'(exp_q.size() > 0 && avail_q[0] <= cyc));
      m_fd = 0;
      // spur is only raised while nothing is in flight
      if (spur) m_err = 1;
      if (m_valid && m_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        void'(avail_q.pop_front());
        chk("m_data", m_data, e[OUT_W-1:0]);
        chk("m_last", 128'(m_last), 128'(e[OUT_W]));
        m_occ--;
      end
      if (s_valid && s_ready) begin
        chk("dp_valid", 128'(dp_valid), 128'(1'b1));
        chk("dp_act", 128'(dp_act), 128'(s_data));
        m_acc++;
        exp_q.push_back({(m_acc == NPIX), dp_fn(s_data)});
        avail_q.push_back(cyc + DP_LAT + 1);
        m_occ++;
        if (m_acc == NPIX) m_run = 0;
      end else begin
        chk("dp_idle", 128'({dp_valid, dp_act}), 128'(0));
      end
      if (m_busy && !m_run && m_occ == 0) begin
        m_busy = 0;
        m_fd = 1;
      end
      if (start_ok) begin
        m_busy = 1; m_run = 1; m_acc = 0;
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // basic back-to-back frame
    sv_mode = 1; mr_mode = 1;
    pulse_start();
    wait_done(100);
    repeat (3) @(posedge clk);

    // backpressure: credit window closes, then drains
    sv_mode = 1; mr_mode = 0;
    pulse_start();
    repeat (12) @(posedge clk);
    mr_mode = 1;
    wait_done(100);
    repeat (3) @(posedge clk);

    // full FIFO with toggling downstream
    sv_mode = 1; mr_mode = 3;
    pulse_start();
    wait_done(200);
    mr_mode = 0; sv_mode = 0;
    repeat (3) @(posedge clk);

    // spurious datapath strobe while idle
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    repeat (4) @(posedge clk);

    // random traffic with start re-asserted mid-frame
    for (int f = 0; f < 5; f++) begin
      sv_mode = 2; mr_mode = 2;
      pulse_start();
      repeat ($urandom_range(1, 4)) @(posedge clk);
      pulse_start();
      wait_done(400);
      repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    // asynchronous reset mid-frame
    sv_mode = 1; mr_mode = 0;
    pulse_start();
    for (int i = 0; i < 20 && m_acc < 3; i++) @(negedge clk);
    @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("async_busy", 128'(busy), 128'(1'b0));
    chk("async_s_ready", 128'(s_ready), 128'(1'b0));
    chk("async_m_valid", 128'(m_valid), 128'(1'b0));
    chk("async_m_last", 128'(m_last), 128'(1'b0));
    chk("async_m_data", m_data, 128'(0));
    chk("async_dp", 128'({dp_valid, dp_act}), 128'(0));
    chk("async_err", 128'(err), 128'(1'b0));
    chk("async_frame_done", 128'(frame_done), 128'(1'b0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    sv_mode = 2; mr_mode = 1;
    pulse_start();
    wait_done(200);
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
